// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates I-cache line fills and LSB loads/stores
// onto a byte-wide RAM/IO bus and returns results with one-cycle done pulses.
module mem_ctrl #(
    parameter int         LINE_BYTES = 64,
    parameter logic [1:0] IO_MASK_HI = 2'b11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full,
    input  logic                    if_en,
    input  logic [31:0]             if_pc,
    output logic                    if_done,
    output logic [8*LINE_BYTES-1:0] if_data,
    input  logic                    lsb_en,
    input  logic                    lsb_wr,
    input  logic [31:0]             lsb_addr,
    input  logic [1:0]              lsb_size,
    input  logic [31:0]             lsb_wdata,
    output logic                    lsb_done,
    output logic [31:0]             lsb_rdata,
    output logic [1:0]              dbg_state
);

    localparam int CW = ($clog2(LINE_BYTES) < 2) ? 2 : $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    // Handshake: a client holds its enable level until its done pulse (or rollback
    // for reads); a request is taken only in IDLE while both done outputs are low.

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d, last_q, last_d, cnt_inc;
    logic [31:0]             base_q, base_d, wdata_q, wdata_d, next_addr;
    logic [8*LINE_BYTES-1:0] line_q, line_d, line_fill, if_data_d;
    logic [31:0]             word_q, word_d, word_fill, lsb_rdata_d;
    logic [31:0]             mem_a_d;
    logic [7:0]              mem_dout_d;
    logic                    wr_q, wr_d, if_done_d, lsb_done_d, stall;

    function automatic logic [CW-1:0] size_last(input logic [1:0] sz);
        case (sz)
            2'd0:    return '0;
            2'd1:    return CW'(1);
            default: return CW'(3);
        endcase
    endfunction

    assign cnt_inc   = cnt_q + CW'(1);
    assign next_addr = base_q + 32'(cnt_inc);
    assign stall     = (state_q == LS_WR) && io_buffer_full && (base_q[17:16] == IO_MASK_HI);
    // The write strobe drops in the very cycle the IO buffer reports full.
    assign mem_wr    = wr_q & ~(rdy & stall);
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        line_d      = line_q;
        word_d      = word_q;
        mem_a_d     = mem_a;
        mem_dout_d  = mem_dout;
        wr_d        = wr_q;
        if_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        if_data_d   = if_data;
        lsb_rdata_d = lsb_rdata;
        line_fill   = line_q;
        line_fill[{cnt_q, 3'b000} +: 8] = mem_din;
        word_fill   = word_q;
        word_fill[{cnt_q[1:0], 3'b000} +: 8] = mem_din;

        case (state_q)
            IDLE: begin
                if (!if_done && !lsb_done) begin
                    if (lsb_en && lsb_wr) begin
                        state_d    = LS_WR;
                        base_d     = lsb_addr;
                        wdata_d    = lsb_wdata;
                        last_d     = size_last(lsb_size);
                        cnt_d      = '0;
                        mem_a_d    = lsb_addr;
                        mem_dout_d = lsb_wdata[7:0];
                        wr_d       = 1'b1;
                    end else if (lsb_en && !rollback) begin
                        state_d = LS_RD;
                        base_d  = lsb_addr;
                        last_d  = size_last(lsb_size);
                        cnt_d   = '0;
                        word_d  = '0;
                        mem_a_d = lsb_addr;
                        wr_d    = 1'b0;
                    end else if (if_en && !rollback) begin
                        state_d = IF_RD;
                        base_d  = if_pc;
                        last_d  = CW'(LINE_BYTES - 1);
                        cnt_d   = '0;
                        mem_a_d = if_pc;
                        wr_d    = 1'b0;
                    end
                end
            end
            IF_RD, LS_RD: begin
                if (rollback) begin
                    state_d = IDLE;
                    mem_a_d = '0;
                end else begin
                    if (state_q == IF_RD) begin
                        line_d = line_fill;
                    end else begin
                        word_d = word_fill;
                    end
                    if (cnt_q == last_q) begin
                        state_d = IDLE;
                        mem_a_d = '0;
                        if (state_q == IF_RD) begin
                            if_done_d = 1'b1;
                            if_data_d = line_fill;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = word_fill;
                        end
                    end else begin
                        cnt_d   = cnt_inc;
                        mem_a_d = next_addr;
                    end
                end
            end
            LS_WR: begin
                // Rollback is ignored here: a store reaching memory is already committed.
                if (!stall) begin
                    if (cnt_q == last_q) begin
                        state_d    = IDLE;
                        wr_d       = 1'b0;
                        lsb_done_d = 1'b1;
                        mem_a_d    = '0;
                    end else begin
                        cnt_d      = cnt_inc;
                        mem_a_d    = next_addr;
                        mem_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= '0;
            base_q    <= '0;
            wdata_q   <= '0;
            line_q    <= '0;
            word_q    <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            wr_q      <= 1'b0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= '0;
            lsb_rdata <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            line_q    <= line_d;
            word_q    <= word_d;
            mem_a     <= mem_a_d;
            mem_dout  <= mem_dout_d;
            wr_q      <= wr_d;
            if_done   <= if_done_d;
            lsb_done  <= lsb_done_d;
            if_data   <= if_data_d;
            lsb_rdata <= lsb_rdata_d;
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sits between the byte-wide RAM/IO bus and the two memory clients: the instruction fetch unit (64-byte I-cache line fills) and the load/store buffer (1/2/4-byte loads and stores).
- Arbitrates between the two clients and serialises each request into byte transfers.
- Returns a full line to fetch, or a word to the LSB, with a one-cycle done pulse.

Parameters:
- LINE_BYTES, 64, bytes per I-cache line fill; if_data width = 8*LINE_BYTES.
- IO_MASK_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- rdy  input  1  global enable; when 0 all state frozen
- rollback  input  1  ROB misprediction flush
- mem_din  input  8  RAM read byte (valid 1 cycle after address)
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write, 0 = read
- io_buffer_full  input  1  IO write buffer full
- if_en  input  1  fetch line request, held until if_done or rollback
- if_pc  input  32  line base address (64-byte aligned)
- if_done  output  1  one-cycle pulse: if_data valid
- if_data  output  8*LINE_BYTES  line, byte i at bits [8i+7:8i]
- lsb_en  input  1  LSB request, held until lsb_done
- lsb_wr  input  1  1 = store, 0 = load
- lsb_addr  input  32  byte address
- lsb_size  input  2  0 = byte, 1 = half, 2 = word (3 illegal, treated as word)
- lsb_wdata  input  32  store data, little-endian
- lsb_done  output  1  one-cycle pulse
- lsb_rdata  output  32  load data, zero-extended; sign extension is done by the LSB

Behaviour:
- Reset:
  - rst is synchronous, active-high; clk rising edge.
  - On reset: state=IDLE, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0, byte counter=0.
- rdy=0: no register changes (mem_wr keeps its value).
- States: IDLE, IF_RD, LS_RD, LS_WR.
  - n = LINE_BYTES for IF_RD.
  - n = 1/2/4 per lsb_size for LS_RD and LS_WR.
- IDLE arbitration:
  - Checked only when both done outputs are 0, so no request is accepted in the cycle a done pulse is high.
  - LSB has priority: lsb_en=1 -> LS_WR or LS_RD.
  - Otherwise if_en=1 and rollback=0 -> IF_RD.
  - A load request with rollback=1 is not accepted.
  - The accept edge E latches the base address and sets counter=0.
- Read (IF_RD, LS_RD):
  - At edge E: mem_a=base, mem_wr=0.
  - At edge E+k (k=1..n): byte k-1 is latched from mem_din into position k-1, and mem_a=base+k while k<n.
  - At edge E+n: the done pulse for that client is set, state=IDLE, mem_a=0.
  - Done is high for exactly the cycle after E+n, so latency is n cycles from accept.
- Write (LS_WR):
  - At edge E: mem_a=addr, mem_dout=wdata byte 0, mem_wr=1.
  - Each following edge writes the next byte.
  - After byte n-1 has been driven for one cycle: mem_wr=0, lsb_done=1, state=IDLE.
- IO stall:
  - In LS_WR, if io_buffer_full=1 and addr[17:16]==IO_MASK_HI, drive mem_wr=0 and do not advance the counter.
  - Resume with the same byte once io_buffer_full=0.
- Rollback:
  - In IF_RD or LS_RD: abort next edge -> IDLE, mem_a=0, no done pulse, partial data discarded.
  - In LS_WR: ignored; committed stores always complete.
  - In IDLE: blocks acceptance of reads that cycle.
- Done outputs are cleared on the edge after their pulse.
- if_data and lsb_rdata hold their last value until the next transfer overwrites them.
- The address counter wraps modulo 2^32; no special handling.

Test Plan:
- Line fill: RAM byte[a]=a[7:0], if_en=1 with if_pc=0x1000.
  - Expect if_done pulse 64 cycles after accept.
  - Expect if_data[7:0]=0x00 and if_data[511:504]=0x3F.
  - Expect mem_wr=0 throughout.
- Word load: lsb_addr=0x2002, size=2, RAM bytes 0x11,0x22,0x33,0x44.
  - Expect lsb_rdata=0x44332211 and lsb_done 4 cycles after accept.
- Byte store: lsb_wr=1, addr=0x30, wdata=0xA5.
  - Expect one cycle with mem_wr=1, mem_a=0x30, mem_dout=0xA5, then lsb_done.
- Simultaneous if_en and lsb_en in IDLE.
  - LSB is served first.
  - IF_RD starts 1 cycle after lsb_done falls.
  - No accept occurs in the cycle lsb_done is high.
- Rollback at byte 20 of a line fill.
  - Returns to IDLE, no if_done pulse.
  - A following LSB load completes normally.
- Word store to 0x30000 with io_buffer_full=1 for 3 cycles after byte 1.
  - mem_wr drops for exactly 3 cycles and byte 2 is repeated afterwards.
  - lsb_done arrives 3 cycles later than the unstalled case.
  - A rollback asserted during the store has no effect.
